uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, tx state type and check-bit helper
package uart_pkg;

  // Check-slot encodings, shared with uart_rx
  localparam int UART_CHECK_NONE = 0;
  localparam int UART_CHECK_ODD  = 1;
  localparam int UART_CHECK_EVEN = 2;

  // Widest data word any UART frame in the family carries
  localparam int UART_MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_CHECK = 3'd3,
    TX_STOP  = 3'd4
  } uart_tx_state_e;

  // Check-slot value for a data word; narrower words are zero-extended,
  // which leaves the reduction XOR unchanged.
  function automatic logic uart_check_bit(
    input logic [UART_MAX_DATA_WIDTH-1:0] data,
    input int                             check
  );
    logic bit_v;
    case (check)
      UART_CHECK_ODD:  bit_v = ~^data;
      UART_CHECK_EVEN: bit_v = ^data;
      default:         bit_v = 1'b1;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, one bit per clock, frame compatible with uart_rx
module uart_tx
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx
);

  localparam int CNT_MAX = (P_UART_DATA_WIDTH > P_UART_STOP_WIDTH) ?
                           P_UART_DATA_WIDTH : P_UART_STOP_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(P_UART_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(P_UART_STOP_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Reject unsupported frame shapes at elaboration
  if (P_UART_DATA_WIDTH < 5 || P_UART_DATA_WIDTH > UART_MAX_DATA_WIDTH) begin : g_bad_data_width
    $error("uart_tx: P_UART_DATA_WIDTH must be in 5..9");
  end
  if (P_UART_STOP_WIDTH != 1 && P_UART_STOP_WIDTH != 2) begin : g_bad_stop_width
    $error("uart_tx: P_UART_STOP_WIDTH must be 1 or 2");
  end
  if (P_UART_CHECK != UART_CHECK_NONE && P_UART_CHECK != UART_CHECK_ODD &&
      P_UART_CHECK != UART_CHECK_EVEN) begin : g_bad_check
    $error("uart_tx: P_UART_CHECK must be 0 (NONE), 1 (ODD) or 2 (EVEN)");
  end
  if (P_UART_BUADRATE <= 0 || P_SYSTEM_CLK < P_UART_BUADRATE) begin : g_bad_rates
    $error("uart_tx: clock/baud rate parameters are inconsistent");
  end

  uart_tx_state_e                 state_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [P_UART_DATA_WIDTH-1:0]   shift_q;
  logic                           check_q;
  logic                           tx_q;
  logic                           init_done_q;

  logic                           last_stop;
  logic                           handshake;
  logic                           new_check;

  // Ready is open in IDLE, or in the final stop cycle so frames chain with no gap
  always_comb begin
    last_stop       = (state_q == TX_STOP) && (cnt_q == STOP_LAST);
    o_user_tx_ready = init_done_q && ((state_q == TX_IDLE) || last_stop);
    handshake       = i_user_tx_valid && o_user_tx_ready;
    new_check       = uart_check_bit(UART_MAX_DATA_WIDTH'(i_user_tx_data), P_UART_CHECK);
  end

  assign o_uart_tx = tx_q;

  // Frame FSM: tx_q always carries the bit of the state being entered
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= TX_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      check_q     <= 1'b0;
      tx_q        <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
      case (state_q)
        TX_IDLE: begin
          cnt_q <= '0;
          if (handshake) begin
            state_q <= TX_START;
            shift_q <= i_user_tx_data;
            check_q <= new_check;
            tx_q    <= 1'b0;
          end else begin
            tx_q    <= 1'b1;
          end
        end
        TX_START: begin
          state_q <= TX_DATA;
          cnt_q   <= '0;
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
        end
        TX_DATA: begin
          if (cnt_q == DATA_LAST) begin
            state_q <= TX_CHECK;
            cnt_q   <= '0;
            tx_q    <= check_q;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        TX_CHECK: begin
          state_q <= TX_STOP;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
        TX_STOP: begin
          if (cnt_q == STOP_LAST) begin
            cnt_q <= '0;
            if (handshake) begin
              state_q <= TX_START;
              shift_q <= i_user_tx_data;
              check_q <= new_check;
              tx_q    <= 1'b0;
            end else begin
              state_q <= TX_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
            tx_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= TX_IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx over three frame configurations
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] valid = 3'b000;
  logic [2:0] ready;
  logic [2:0] tx;
  logic [8:0] din [3];

  int dw_t [3] = '{8, 8, 9};
  int sw_t [3] = '{1, 2, 1};
  int ck_t [3] = '{0, 1, 2};

  bit exp_q [3][$];
  bit init_m = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  initial forever #5 clk = ~clk;

  uart_tx #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_user_tx_data(din[0][7:0]),
    .i_user_tx_valid(valid[0]), .o_user_tx_ready(ready[0]), .o_uart_tx(tx[0]));

  uart_tx #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(1)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_user_tx_data(din[1][7:0]),
    .i_user_tx_valid(valid[1]), .o_user_tx_ready(ready[1]), .o_uart_tx(tx[1]));

  uart_tx #(.P_UART_DATA_WIDTH(9), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_user_tx_data(din[2]),
    .i_user_tx_valid(valid[2]), .o_user_tx_ready(ready[2]), .o_uart_tx(tx[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line sequence for one frame, built from the frame rules
  function automatic void push_frame(input int k, input logic [8:0] d);
    int ones;
    bit slot;
    ones = 0;
    exp_q[k].push_back(1'b0);
    for (int i = 0; i < dw_t[k]; i++) begin
      exp_q[k].push_back(d[i]);
      if (d[i]) ones++;
    end
    if (ck_t[k] == 1)      slot = ((ones % 2) == 0);
    else if (ck_t[k] == 2) slot = ((ones % 2) == 1);
    else                   slot = 1'b1;
    exp_q[k].push_back(slot);
    for (int i = 0; i < sw_t[k]; i++) exp_q[k].push_back(1'b1);
  endfunction

  // Model of acceptance: a word is taken when the line is free (no bits left to send)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) exp_q[k].delete();
      init_m = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (valid[k] && init_m && exp_q[k].size() == 0) push_frame(k, din[k]);
      init_m = 1'b1;
    end
  end

  // Monitor: every cycle compare line and ready against the scoreboard
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        chk($sformatf("reset tx[%0d]", k), 32'(tx[k]), 32'd1);
        chk($sformatf("reset ready[%0d]", k), 32'(ready[k]), 32'd0);
      end else begin
        bit exp_rdy;
        bit exp_bit;
        exp_rdy = init_m && (exp_q[k].size() <= 1);
        exp_bit = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 1'b1;
        chk($sformatf("ready[%0d]", k), 32'(ready[k]), 32'(exp_rdy));
        chk($sformatf("tx[%0d]", k), 32'(tx[k]), 32'(exp_bit));
      end
    end
  end

  task automatic send(input int k, input logic [8:0] d, input bit hold);
    int t;
    t = 0;
    @(negedge clk);
    din[k]   = d;
    valid[k] = 1'b1;
    while (!ready[k] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ready[k]) begin
      n_checks++;
      n_fail++;
      $display("FAIL send timeout dut%0d: ready got 0, required 1", k);
      valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    din[k] = 9'($urandom);
    if (!hold) valid[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) din[k] = '0;
    idle(3);
    #2 rst_n = 1'b1;

    // Directed frames
    send(0, 9'h055, 1'b0); idle(14);
    send(1, 9'h0A5, 1'b0); idle(14);
    send(2, 9'h007, 1'b0); idle(14);
    send(2, 9'h00F, 1'b0); idle(14);
    send(0, 9'h03C, 1'b1);
    send(0, 9'h0C3, 1'b0); idle(14);
    send(1, 9'h0FF, 1'b0); idle(14);
    send(2, 9'h1FF, 1'b0); idle(14);
    send(0, 9'h012, 1'b0);
    din[0] = 9'h0EE;
    idle(14);

    // Asynchronous reset in the middle of data bit 3
    send(0, 9'h000, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    chk("tx0 in data bit 3", 32'(tx[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async reset tx[%0d]", k), 32'(tx[k]), 32'd1);
      chk($sformatf("async reset ready[%0d]", k), 32'(ready[k]), 32'd0);
    end
    idle(2);
    #2 rst_n = 1'b1;
    #1;
    chk("ready0 before first clock", 32'(ready[0]), 32'd0);
    send(0, 9'h081, 1'b0); idle(14);

    // Random bursts on random instances
    for (int it = 0; it < 60; it++) begin
      int k;
      int burst;
      k = int'($urandom_range(0, 2));
      burst = int'($urandom_range(1, 3));
      for (int b = 0; b < burst; b++) send(k, 9'($urandom), (b != burst - 1));
      idle(int'($urandom_range(0, 4)));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
